// File: rtl/program_sequencer_if.sv
// Control/fetch-address bundle between decode logic and the program sequencer.
// The decode side owns the op fields; the sequencer owns pc and status.
interface program_sequencer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);

    logic                   stall;
    logic [2:0]             op;
    logic                   cond;
    logic [PC_WIDTH-1:0]    target;
    logic [PC_WIDTH-1:0]    offset;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_next;
    logic                   halted;
    logic [DEPTH_WIDTH-1:0] depth;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output stall, op, cond, target, offset,
        input  pc, pc_next, halted, depth, overflow, underflow
    );

    modport slave (
        input  stall, op, cond, target, offset,
        output pc, pc_next, halted, depth, overflow, underflow
    );
endinterface

// File: rtl/program_sequencer.sv
// Instruction fetch-address sequencer: advance, stall, jump, relative branch,
// call/return through a return-address stack, and halt.
module program_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STEP        = 1,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    program_sequencer_if.slave  bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_SEQ    = 3'b000;
    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_HALT   = 3'b101;

    typedef enum logic {RUN, HALT} state_t;

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_calc;
    logic [DW-1:0]       depth_reg, depth_next, depth_dec;
    logic                overflow_reg, overflow_next;
    logic                underflow_reg, underflow_next;
    logic                push_en;
    logic [IW-1:0]       push_idx, pop_idx;
    logic [PC_WIDTH-1:0] seq_addr;
    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

    assign seq_addr  = pc_reg + PC_WIDTH'(STEP);
    assign depth_dec = depth_reg - DW'(1);
    assign push_idx  = depth_reg[IW-1:0];
    assign pop_idx   = depth_dec[IW-1:0];

    always_comb begin
        state_next     = state_reg;
        pc_calc        = pc_reg;
        depth_next     = depth_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        push_en        = 1'b0;
        if (state_reg == RUN && !bus.stall) begin
            case (bus.op)
                OP_JUMP:   pc_calc = bus.target;
                // Same-width add wraps, so the offset acts as sign-extended.
                OP_BRANCH: pc_calc = bus.cond ? (pc_reg + bus.offset) : seq_addr;
                OP_CALL: begin
                    if (depth_reg == DW'(STACK_DEPTH)) begin
                        overflow_next = 1'b1;
                        state_next    = HALT;
                    end else begin
                        push_en    = 1'b1;
                        depth_next = depth_reg + DW'(1);
                        pc_calc    = bus.target;
                    end
                end
                OP_RET: begin
                    if (depth_reg == '0) begin
                        underflow_next = 1'b1;
                        state_next     = HALT;
                    end else begin
                        pc_calc    = stack[pop_idx];
                        depth_next = depth_dec;
                    end
                end
                OP_HALT:   state_next = HALT;
                OP_SEQ:    pc_calc = seq_addr;
                default:   pc_calc = seq_addr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= RUN;
            pc_reg        <= PC_WIDTH'(RESET_PC);
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_calc;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Stack contents are don't-care after reset, so entries carry no reset.
    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            always_ff @(posedge clk) begin
                if (rst && push_en && push_idx == IW'(gi))
                    stack[gi] <= seq_addr;
            end
        end
    endgenerate

    assign bus.pc        = pc_reg;
    assign bus.pc_next   = !rst ? PC_WIDTH'(RESET_PC) : pc_calc;
    assign bus.halted    = (state_reg == HALT);
    assign bus.depth     = depth_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the free-running 8-bit PC.
- Generates the instruction-memory fetch address each cycle.
- Supports sequential advance, stall, absolute jump, conditional PC-relative branch, call/return via an internal return-address stack, and halt.
- Sits between the decode/control logic, which supplies op/target/offset/cond, and the instruction memory address input.

Parameters:
- PC_WIDTH, 8: width of pc, target and offset, in bits.
- STEP, 1: increment per sequential advance, in address units.
- RESET_PC, 0: pc value loaded on reset.
- STACK_DEPTH, 4: return-address stack entries (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- stall  input  1  1 = hold all state this cycle; op is ignored.
- op  input  3  000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101 HALT, 110/111 treated as SEQ.
- cond  input  1  branch condition, used by BRANCH only.
- target  input  PC_WIDTH  absolute destination for JUMP/CALL.
- offset  input  PC_WIDTH  two's-complement displacement for BRANCH.
- pc  output  PC_WIDTH  current fetch address (registered).
- pc_next  output  PC_WIDTH  combinational value pc will take at the next edge.
- halted  output  1  1 = sequencer stopped.
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky; CALL was attempted with the stack full.
- underflow  output  1  sticky; RET was attempted with the stack empty.

Behaviour:
- Reset: sampled only at the rising clk edge while rst=0. Reset has priority over everything, including mid-call and halted state.
  - pc=RESET_PC, halted=0, depth=0, overflow=0, underflow=0.
  - Stack contents are don't-care.
- States:
  - RUN: the normal state.
  - HALT: entered from RUN on HALT, an overflowing CALL, or an underflowing RET. Exited only by reset.
  - In HALT, pc, depth and flags hold, and all ops and stall are ignored.
- Latency: one cycle. An op presented in cycle N determines pc in cycle N+1. pc_next always equals the value that will be registered.
- Stall (RUN): pc, stack and depth hold, and pc_next=pc. Stall masks HALT too.
- SEQ: pc ← pc+STEP, mod 2^PC_WIDTH. Wrap is silent: 0xFF+1 → 0x00 at width 8.
- JUMP: pc ← target.
- BRANCH:
  - cond=1: pc ← pc+offset, mod 2^PC_WIDTH, with offset sign-extended. For example, offset 0xFE means −2.
  - cond=0: pc ← pc+STEP.
- CALL:
  - depth<STACK_DEPTH: push (pc+STEP) mod 2^PC_WIDTH, depth+1, pc ← target.
  - depth==STACK_DEPTH: no push, pc holds, overflow ← 1, halted ← 1.
- RET:
  - depth>0: pc ← top entry, pop, depth−1.
  - depth==0: pc holds, underflow ← 1, halted ← 1.
- HALT: pc holds, halted ← 1.
- Stack is LIFO and contains only return addresses. The stack is not modified by JUMP/BRANCH/SEQ.
- overflow and underflow are never both set by a single cycle. Once set, they clear only on reset.
- halted goes high in the cycle after the causing op edge, the same edge at which pc is registered.

Test Plan:
- Reset/SEQ: rst=0 one edge, then op=SEQ ×3 → pc 0,1,2,3. With PC_WIDTH=8, preload pc=0xFE via JUMP, then SEQ ×2 → 0xFF, 0x00.
- Stall and branch:
  - pc=0x10, stall=1 with op=JUMP target=0x80 → pc stays 0x10.
  - stall=0, BRANCH cond=1 offset=0xFC → pc=0x0C.
  - BRANCH cond=0 → pc=0x0D.
- Nested call/return (STACK_DEPTH=4):
  - At pc=0x05, CALL 0x40 → pc=0x40, depth=1.
  - At 0x40, CALL 0x60 → pc=0x60, depth=2.
  - RET → pc=0x41, depth=1.
  - RET → pc=0x06, depth=0.
- Overflow: 4 CALLs fill the stack (depth=4). A 5th CALL → pc unchanged, overflow=1, halted=1. A subsequent RET is ignored, with depth still 4.
- Underflow and HALT:
  - From reset, RET → underflow=1, halted=1, pc=RESET_PC.
  - Separate run: HALT at pc=0x22, then SEQ ×5 → pc stays 0x22.
- Reset mid-operation: with depth=2 and halted=1, rst=0 for one edge → pc=RESET_PC, depth=0, flags 0. The next SEQ advances normally.
